// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, addresses the combinational ROM and fills IF/ID.
// Optional macro IFETCH_BOUND_CHECK_EN adds a sticky fetch_fault for fetches beyond the ROM.
module fetch_controller #(
   parameter int          Inst_Num     = 150,
   parameter int          Inst_Num_BIT = 8,
   parameter logic [31:0] RESET_PC     = 32'h0000_0000
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    stall,
   input  logic                    redirect_valid,
   input  logic [31:0]             redirect_pc,
   output logic [Inst_Num_BIT-1:0] imem_addr,
   input  logic [31:0]             imem_data,
   output logic                    if_valid,
   output logic [31:0]             if_inst,
   output logic [31:0]             if_pc,
   output logic [31:0]             if_pc_plus4,
   output logic                    misalign_flag,
   output logic [31:0]             fetch_count,
   output logic [31:0]             bubble_count
`ifdef IFETCH_BOUND_CHECK_EN
   ,
   output logic                    fetch_fault
`endif
);

   typedef enum logic [1:0] {BOOT, RUN, SQUASH} state_t;

   state_t      state, state_nx;
   logic [31:0] pc, pc_nx, pc_plus4;
   logic [31:0] inst_nx, if_pc_nx, if_pc_plus4_nx;
   logic        valid_nx, misalign_nx, fetch;
   logic [31:0] fetch_count_nx, bubble_count_nx;

   // A ROM larger than the word-address space could never be fully addressed.
   if (Inst_Num > (1 << Inst_Num_BIT)) begin : g_rom_size_check
      $error("Inst_Num exceeds the ROM word-address space");
   end

   assign pc_plus4  = pc + 32'd4;
   assign imem_addr = pc[Inst_Num_BIT+1:2];

`ifdef IFETCH_BOUND_CHECK_EN
   logic out_of_range, fault_nx;
   assign out_of_range = (pc[31:2] >= 30'(Inst_Num)) || (pc[31:Inst_Num_BIT+2] != '0);
`endif

   always_comb begin
      state_nx       = state;
      pc_nx          = pc;
      inst_nx        = if_inst;
      if_pc_nx       = if_pc;
      if_pc_plus4_nx = if_pc_plus4;
      valid_nx       = if_valid;
      misalign_nx    = misalign_flag;
      fetch          = 1'b0;
`ifdef IFETCH_BOUND_CHECK_EN
      fault_nx       = fetch_fault;
`endif
      case (state)
         BOOT: state_nx = RUN;
         RUN, SQUASH: begin
            // Redirect beats stall: the word fetched this cycle is on the wrong path.
            if (redirect_valid) begin
               state_nx = SQUASH;
               pc_nx    = {redirect_pc[31:2], 2'b00};
               valid_nx = 1'b0;
               inst_nx  = '0;
               if (redirect_pc[1:0] != 2'b00) misalign_nx = 1'b1;
            end else if (stall) begin
               if (state == SQUASH) valid_nx = 1'b0;
            end else begin
               fetch    = 1'b1;
               state_nx = RUN;
            end
         end
         default: state_nx = BOOT;
      endcase

      if (fetch) begin
         inst_nx        = imem_data;
         if_pc_nx       = pc;
         if_pc_plus4_nx = pc_plus4;
         valid_nx       = 1'b1;
         pc_nx          = pc_plus4;
`ifdef IFETCH_BOUND_CHECK_EN
         if (out_of_range) begin
            inst_nx  = '0;
            fault_nx = 1'b1;
         end
`endif
      end

      fetch_count_nx  = fetch ? fetch_count + 32'd1 : fetch_count;
      bubble_count_nx = ((state != BOOT) && !valid_nx) ? bubble_count + 32'd1 : bubble_count;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= BOOT;
         pc            <= RESET_PC;
         if_valid      <= 1'b0;
         if_inst       <= '0;
         if_pc         <= '0;
         if_pc_plus4   <= '0;
         misalign_flag <= 1'b0;
         fetch_count   <= '0;
         bubble_count  <= '0;
`ifdef IFETCH_BOUND_CHECK_EN
         fetch_fault   <= 1'b0;
`endif
      end else begin
         state         <= state_nx;
         pc            <= pc_nx;
         if_valid      <= valid_nx;
         if_inst       <= inst_nx;
         if_pc         <= if_pc_nx;
         if_pc_plus4   <= if_pc_plus4_nx;
         misalign_flag <= misalign_nx;
         fetch_count   <= fetch_count_nx;
         bubble_count  <= bubble_count_nx;
`ifdef IFETCH_BOUND_CHECK_EN
         fetch_fault   <= fault_nx;
`endif
      end
   end

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: table of per-edge vectors through a scoreboard queue,
// plus hand sequences for asynchronous mid-stream reset and the optional bound check.
module tb_fetch_controller;
   localparam int IW = 8;
   localparam int NV = 23;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          stall = 1'b0;
   logic          redirect_valid = 1'b0;
   logic [31:0]   redirect_pc = 32'h0;
   logic [IW-1:0] imem_addr;
   logic [31:0]   imem_data;
   logic          if_valid;
   logic [31:0]   if_inst, if_pc, if_pc_plus4;
   logic          misalign_flag;
   logic [31:0]   fetch_count, bubble_count;
`ifdef IFETCH_BOUND_CHECK_EN
   logic          fetch_fault;
`endif

   logic [31:0] rom [0:255];
   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;
   assign imem_data = rom[imem_addr];

   fetch_controller #(.Inst_Num(150), .Inst_Num_BIT(IW), .RESET_PC(32'h0)) dut (
      .clk(clk), .reset(reset), .stall(stall),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_addr(imem_addr), .imem_data(imem_data),
      .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4),
      .misalign_flag(misalign_flag), .fetch_count(fetch_count), .bubble_count(bubble_count)
`ifdef IFETCH_BOUND_CHECK_EN
      , .fetch_fault(fetch_fault)
`endif
   );

   typedef struct {
      logic        stall;
      logic        rv;
      logic [31:0] rpc;
      logic        valid;
      logic [31:0] ifpc;
      logic [31:0] pc_after;
      logic [31:0] fc;
      logic [31:0] bc;
      logic        mis;
   } vec_t;

   vec_t vecs [NV];
   vec_t sbq [$];
   vec_t e;

   function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rp,
                               input logic v, input logic [31:0] ip, input logic [31:0] pa,
                               input logic [31:0] f, input logic [31:0] b, input logic m);
      vec_t t;
      t.stall = s; t.rv = r; t.rpc = rp; t.valid = v; t.ifpc = ip;
      t.pc_after = pa; t.fc = f; t.bc = b; t.mis = m;
      return t;
   endfunction

   function automatic logic [31:0] rom_word(input logic [31:0] p);
`ifdef IFETCH_BOUND_CHECK_EN
      if (p[31:2] >= 30'd150) return 32'h0;
`endif
      return rom[p[9:2]];
   endfunction

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s[%0d] got=%h want=%h", nm, idx, act, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = 32'h2400_0000 + i;
      rom[0] = 32'h3C01_6165;
      rom[1] = 32'h3421_6165;

      //            stall rv    rpc           valid ifpc          pc_after      fc  bc  mis
      vecs[0]  = mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0,        0,  0,  1'b0);
      vecs[1]  = mk(1'b0, 1'b0, 32'h0,        1'b1, 32'h0,        32'h4,        1,  0,  1'b0);
      vecs[2]  = mk(1'b0, 1'b0, 32'h0,        1'b1, 32'h4,        32'h8,        2,  0,  1'b0);
      vecs[3]  = mk(1'b1, 1'b0, 32'h0,        1'b1, 32'h4,        32'h8,        2,  0,  1'b0);
      vecs[4]  = mk(1'b1, 1'b0, 32'h0,        1'b1, 32'h4,        32'h8,        2,  0,  1'b0);
      vecs[5]  = mk(1'b1, 1'b0, 32'h0,        1'b1, 32'h4,        32'h8,        2,  0,  1'b0);
      vecs[6]  = mk(1'b0, 1'b0, 32'h0,        1'b1, 32'h8,        32'hC,        3,  0,  1'b0);
      vecs[7]  = mk(1'b0, 1'b1, 32'h58,       1'b0, 32'h8,        32'h58,       3,  1,  1'b0);
      vecs[8]  = mk(1'b0, 1'b0, 32'h0,        1'b1, 32'h58,       32'h5C,       4,  1,  1'b0);
      vecs[9]  = mk(1'b0, 1'b1, 32'h54,       1'b0, 32'h58,       32'h54,       4,  2,  1'b0);
      vecs[10] = mk(1'b0, 1'b0, 32'h0,        1'b1, 32'h54,       32'h58,       5,  2,  1'b0);
      vecs[11] = mk(1'b1, 1'b1, 32'h88,       1'b0, 32'h54,       32'h88,       5,  3,  1'b0);
      vecs[12] = mk(1'b1, 1'b0, 32'h0,        1'b0, 32'h54,       32'h88,       5,  4,  1'b0);
      vecs[13] = mk(1'b1, 1'b0, 32'h0,        1'b0, 32'h54,       32'h88,       5,  5,  1'b0);
      vecs[14] = mk(1'b0, 1'b0, 32'h0,        1'b1, 32'h88,       32'h8C,       6,  5,  1'b0);
      vecs[15] = mk(1'b0, 1'b1, 32'h1D6,      1'b0, 32'h88,       32'h1D4,      6,  6,  1'b1);
      vecs[16] = mk(1'b0, 1'b0, 32'h0,        1'b1, 32'h1D4,      32'h1D8,      7,  6,  1'b1);
      vecs[17] = mk(1'b0, 1'b1, 32'h20,       1'b0, 32'h1D4,      32'h20,       7,  7,  1'b1);
      vecs[18] = mk(1'b0, 1'b1, 32'h30,       1'b0, 32'h1D4,      32'h30,       7,  8,  1'b1);
      vecs[19] = mk(1'b0, 1'b0, 32'h0,        1'b1, 32'h30,       32'h34,       8,  8,  1'b1);
      vecs[20] = mk(1'b0, 1'b1, 32'hFFFFFFFC, 1'b0, 32'h30,       32'hFFFFFFFC, 8,  9,  1'b1);
      vecs[21] = mk(1'b0, 1'b0, 32'h0,        1'b1, 32'hFFFFFFFC, 32'h0,        9,  9,  1'b1);
      vecs[22] = mk(1'b1, 1'b0, 32'h0,        1'b1, 32'hFFFFFFFC, 32'h0,        9,  9,  1'b1);

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 0, {31'h0, if_valid}, 32'h0);
      chk("rst_inst", 0, if_inst, 32'h0);
      chk("rst_pc", 0, if_pc, 32'h0);
      chk("rst_pc4", 0, if_pc_plus4, 32'h0);
      chk("rst_addr", 0, {24'h0, imem_addr}, 32'h0);
      chk("rst_fc", 0, fetch_count, 32'h0);
      chk("rst_bc", 0, bubble_count, 32'h0);
      chk("rst_mis", 0, {31'h0, misalign_flag}, 32'h0);

      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < NV; i++) begin
         stall          = vecs[i].stall;
         redirect_valid = vecs[i].rv;
         redirect_pc    = vecs[i].rpc;
         sbq.push_back(vecs[i]);
         @(posedge clk);
         #1;
         if (sbq.size() == 0) begin
            chk("sb_empty", i, 32'h1, 32'h0);
         end else begin
            e = sbq.pop_front();
            chk("valid", i, {31'h0, if_valid}, {31'h0, e.valid});
            chk("inst", i, if_inst, e.valid ? rom_word(e.ifpc) : 32'h0);
            chk("if_pc", i, if_pc, e.ifpc);
            if (e.valid) chk("pc4", i, if_pc_plus4, e.ifpc + 32'd4);
            chk("addr", i, {24'h0, imem_addr}, {24'h0, e.pc_after[9:2]});
            chk("fc", i, fetch_count, e.fc);
            chk("bc", i, bubble_count, e.bc);
            chk("mis", i, {31'h0, misalign_flag}, {31'h0, e.mis});
         end
         @(negedge clk);
      end

      // asynchronous reset mid-stream with stall and redirect both asserted
      stall = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 32'h40;
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      chk("mid_valid", 0, {31'h0, if_valid}, 32'h0);
      chk("mid_inst", 0, if_inst, 32'h0);
      chk("mid_pc", 0, if_pc, 32'h0);
      chk("mid_addr", 0, {24'h0, imem_addr}, 32'h0);
      chk("mid_fc", 0, fetch_count, 32'h0);
      chk("mid_bc", 0, bubble_count, 32'h0);
      chk("mid_mis", 0, {31'h0, misalign_flag}, 32'h0);
`ifdef IFETCH_BOUND_CHECK_EN
      chk("mid_fault", 0, {31'h0, fetch_fault}, 32'h0);
`endif
      @(negedge clk);
      stall = 1'b0;
      redirect_valid = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("boot_valid", 1, {31'h0, if_valid}, 32'h0);
      @(posedge clk);
      #1;
      chk("re_inst", 1, if_inst, 32'h3C01_6165);
      chk("re_pc4", 1, if_pc_plus4, 32'h4);
      chk("re_fc", 1, fetch_count, 32'h1);

`ifdef IFETCH_BOUND_CHECK_EN
      @(negedge clk);
      redirect_valid = 1'b1;
      redirect_pc = 32'h258;
      @(posedge clk);
      #1;
      chk("bnd_squash", 2, {31'h0, if_valid}, 32'h0);
      @(negedge clk);
      redirect_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("bnd_valid", 2, {31'h0, if_valid}, 32'h1);
      chk("bnd_inst", 2, if_inst, 32'h0);
      chk("bnd_pc", 2, if_pc, 32'h258);
      chk("bnd_fault", 2, {31'h0, fetch_fault}, 32'h1);
      #2;
      reset = 1'b0;
      #1;
      chk("bnd_rst_fault", 2, {31'h0, fetch_fault}, 32'h0);
      chk("bnd_rst_valid", 2, {31'h0, if_valid}, 32'h0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
